// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path (and the future transmitter):
//   - UART_DATA_BITS : character width (8N1 framing)
//   - uart_rx_state_e: receiver FSM state encoding
//   - uart_calc_div  : clocks per oversample tick, floored at 1
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_rx_state_e;

  // Integer division; a clock slower than BAUD*OVERSAMPLE still ticks every clk.
  function automatic int uart_calc_div(input int clk_freq, input int baud,
                                       input int oversample);
    int d;
    d = clk_freq / (baud * oversample);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider producing a one-clk tick every DIV clocks.
// Ports:
//   clk     in  system clock
//   reset   in  asynchronous active-high reset
//   restart in  force the count back to 0 (phase-align to an external event)
//   tick    out high for one clk when the count sits at DIV-1
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receive front end, 16x (OVERSAMPLE) sampling, polled status flags.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   uart_rx   in   raw serial line, idle high, asynchronous to clk
//   rd_ack    in   CPU read strobe; clears rx_ready, frame_err, overrun
//   rx_data   out  last correctly framed byte
//   rx_valid  out  one-clk pulse when rx_data updates
//   rx_ready  out  sticky "unread byte held"
//   frame_err out  sticky, stop bit sampled low
//   overrun   out  sticky, byte completed while rx_ready=1 and not acked
//   busy      out  FSM not idle
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | line idle, waiting for a falling edge on rx_s
// ST_START     | counting to mid start bit; re-check low to reject glitches
// ST_DATA      | sampling 8 data bits at mid-bit, LSB first
// ST_STOP      | sampling stop bit; deliver byte or flag framing error
// ST_WAIT_HIGH | framing error seen; hold until line returns high (break)
// -----------------------------------------------------------------------------
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      uart_rx,
  input  logic                      rd_ack,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam int DIV = uart_calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BIW = $clog2(UART_DATA_BITS);

  localparam logic [SCW-1:0] SC_MID  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [BIW-1:0] BI_LAST = BIW'(UART_DATA_BITS - 1);

  // Synchronizer resets high so releasing reset never looks like a start bit.
  logic sync1_q;
  logic rx_s_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      rx_s_q  <= sync1_q;
    end
  end

  uart_rx_state_e            state_q;
  logic [SCW-1:0]            sc_q;
  logic [BIW-1:0]            bi_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] shift_d;
  logic [UART_DATA_BITS-1:0] rx_data_q;
  logic                      rx_valid_q;
  logic                      rx_ready_q;
  logic                      frame_err_q;
  logic                      overrun_q;

  logic restart;
  logic tick;

  // Restart the divider on the same edge the FSM leaves IDLE.
  assign restart = (state_q == ST_IDLE) && !rx_s_q;
  assign shift_d = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sc_q        <= '0;
      bi_q        <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;

      // Ack clears first; a same-cycle completion event below overrides it.
      if (rd_ack) begin
        rx_ready_q  <= 1'b0;
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_q <= ST_START;
            sc_q    <= '0;
          end
        end

        ST_START: begin
          if (tick) begin
            if (sc_q == SC_MID) begin
              sc_q <= '0;
              if (!rx_s_q) begin
                state_q <= ST_DATA;
                bi_q    <= '0;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              sc_q <= sc_q + SCW'(1);
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (sc_q == SC_LAST) begin
              sc_q    <= '0;
              shift_q <= shift_d;
              if (bi_q == BI_LAST) state_q <= ST_STOP;
              else                 bi_q    <= bi_q + BIW'(1);
            end else begin
              sc_q <= sc_q + SCW'(1);
            end
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (sc_q == SC_LAST) begin
              sc_q <= '0;
              if (rx_s_q) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
                rx_ready_q <= 1'b1;
                if (rx_ready_q && !rd_ack) overrun_q <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= ST_WAIT_HIGH;
              end
            end else begin
              sc_q <= sc_q + SCW'(1);
            end
          end
        end

        ST_WAIT_HIGH: begin
          if (rx_s_q) state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_ready  = rx_ready_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
